// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - F3_* : RV32M funct3 encodings
//   - state_t : sequencer FSM states
//   - XLEN_DEFAULT : default operand/result width
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational sign correction and field select.
// The datapath works on magnitudes; this block re-applies the sign and
// picks the architectural result for the op.
//   funct3        : RV32M op
//   prod          : unsigned 2*XLEN product of magnitudes
//   quo, rem      : unsigned quotient / remainder of magnitudes
//   neg_p/q/r     : negate product / quotient / remainder
//   result        : corrected XLEN result
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]        funct3,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  input  logic              neg_p,
  input  logic              neg_q,
  input  logic              neg_r,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] p_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  always_comb begin
    p_fix = neg_p ? ((2*XLEN)'(0) - prod) : prod;
    q_fix = neg_q ? (XLEN'(0) - quo) : quo;
    r_fix = neg_r ? (XLEN'(0) - rem) : rem;
    result = '0;
    case (funct3)
      F3_MUL:                        result = p_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = p_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = q_fix;
      default:                       result = r_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 iterative RV32M multiply/divide unit with FSM.
// Operands are converted to magnitudes on start, iterated one bit per cycle
// (shift-add multiply, restoring divide), then sign corrected in FINISH.
//   clk, rst_n      : clock, async active-low reset
//   start, flush    : request (sampled in IDLE) / abort
//   funct3          : RV32M op select
//   operand_a/b     : rs1 / rs2
//   busy            : operation in progress (pipeline stall)
//   done            : one-cycle result-valid pulse
//   result          : result, held until next done
// Optional: MULDIV_EARLY_OUT_EN ends multiplies once the remaining
// multiplier bits are all zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        f3_q;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mcand;   // |a| shifted left once per step
  logic [XLEN-1:0]   mplier;  // |b| shifted right once per step
  logic [XLEN-1:0]   quo;     // dividend shifts out the top, quotient in
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvsr;
  logic [CNT_W-1:0]  cnt;
  logic              neg_p, neg_q, neg_r;

  // Start-time decode. Magnitudes fit in XLEN unsigned bits, including
  // |-2^(XLEN-1)|, so the product of magnitudes never overflows 2*XLEN.
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa       = a_signed & operand_a[XLEN-1];
    sb       = b_signed & operand_b[XLEN-1];
    mag_a    = sa ? (XLEN'(0) - operand_a) : operand_a;
    mag_b    = sb ? (XLEN'(0) - operand_b) : operand_b;
    div_zero = funct3[2] && (operand_b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (operand_a == INT_MIN) && (operand_b == '1);
  end

  // Restoring divide step: bring in the next dividend bit, subtract if it fits.
  logic [XLEN:0] trial, diff;
  always_comb begin
    trial = {rem, quo[XLEN-1]};
    diff  = trial - {1'b0, dvsr};
  end

  logic [XLEN-1:0] fix_res;
  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .funct3 (f3_q),
    .prod   (prod),
    .quo    (quo),
    .rem    (rem),
    .neg_p  (neg_p),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .result (fix_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      f3_q   <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush && (state != S_IDLE)) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            f3_q   <= funct3;
            prod   <= '0;
            mcand  <= {{XLEN{1'b0}}, mag_a};
            mplier <= mag_b;
            quo    <= mag_a;
            rem    <= '0;
            dvsr   <= mag_b;
            cnt    <= '0;
            neg_p  <= sa ^ sb;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            busy   <= 1'b1;
            state  <= S_CALC;
            // Fast paths preload the final unsigned fields with no sign fix.
            if (div_zero) begin
              quo   <= '1;
              rem   <= operand_a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FINISH;
            end else if (div_ovf) begin
              quo   <= INT_MIN;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FINISH;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (!funct3[2] && (operand_b == '0)) begin
              state <= S_FINISH;
            end
`endif
          end
        end

        S_CALC: begin
          if (!f3_q[2]) begin
            // Adds into a fixed-position accumulator, so stopping early
            // leaves the product correctly aligned.
            prod   <= prod + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
`ifdef MULDIV_EARLY_OUT_EN
            if (mplier == '0) state <= S_FINISH;
`endif
          end else begin
            if (!diff[XLEN]) begin
              rem <= diff[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FINISH;
        end

        S_FINISH: begin
          result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end

        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
